// File: rtl/ac_stream_matcher.sv
// ac_stream_matcher
//   Aho-Corasick stream matcher. One character is accepted at a time; the
//   goto table is searched in parallel, and on a miss the failure chain is
//   walked one hop per cycle until a goto hit or the root is reached.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   IN_VALID/IN_CHAR/IN_LAST  character stream input, IN_READY = accept
//   TBL_WE/SEL/ADDR/WDATA     table write port (goto, failure, output)
//   MATCH_VALID/ID/POS        one-cycle match report
//   STATE_OUT                 current automaton state
//   BUSY                      lookup in progress
//   ERR                       sticky failure-chain overrun flag
module ac_stream_matcher #(
    parameter int unsigned CHAR_W     = 8,
    parameter int unsigned STATE_W    = 8,
    parameter int unsigned GOTO_DEPTH = 32,
    parameter int unsigned NUM_STATES = 32,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned POS_W      = 16
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            IN_VALID,
    input  logic [CHAR_W-1:0]               IN_CHAR,
    input  logic                            IN_LAST,
    output logic                            IN_READY,
    input  logic                            TBL_WE,
    input  logic [1:0]                      TBL_SEL,
    input  logic [7:0]                      TBL_ADDR,
    input  logic [2*STATE_W+CHAR_W:0]       TBL_WDATA,
    output logic                            MATCH_VALID,
    output logic [ID_W-1:0]                 MATCH_ID,
    output logic [POS_W-1:0]                MATCH_POS,
    output logic [STATE_W-1:0]              STATE_OUT,
    output logic                            BUSY,
    output logic                            ERR
);

    localparam int unsigned HOP_W = $clog2(NUM_STATES + 1);

    typedef enum logic {IDLE, LOOKUP} fsm_e;

    fsm_e fsm_q, fsm_d;

    logic [STATE_W-1:0] state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [HOP_W-1:0]   hop_q, hop_d;
    logic [CHAR_W-1:0]  char_q, char_d;
    logic               last_q, last_d;
    logic               mv_q, mv_d;
    logic [ID_W-1:0]    mid_q, mid_d;
    logic [POS_W-1:0]   mpos_q, mpos_d;
    logic               err_q, err_d;

    logic               g_valid_q [GOTO_DEPTH];
    logic               g_valid_d [GOTO_DEPTH];
    logic [STATE_W-1:0] g_cur_q   [GOTO_DEPTH];
    logic [STATE_W-1:0] g_cur_d   [GOTO_DEPTH];
    logic [CHAR_W-1:0]  g_chr_q   [GOTO_DEPTH];
    logic [CHAR_W-1:0]  g_chr_d   [GOTO_DEPTH];
    logic [STATE_W-1:0] g_nxt_q   [GOTO_DEPTH];
    logic [STATE_W-1:0] g_nxt_d   [GOTO_DEPTH];
    logic [STATE_W-1:0] fail_q    [NUM_STATES];
    logic [STATE_W-1:0] fail_d    [NUM_STATES];
    logic [ID_W-1:0]    out_q     [NUM_STATES];
    logic [ID_W-1:0]    out_d     [NUM_STATES];

    logic               hit;
    logic [STATE_W-1:0] hit_nxt;
    logic [STATE_W-1:0] fail_rd;
    logic [ID_W-1:0]    out_rd;
    logic               complete;

    // Table write port; only honoured while idle so a lookup never sees a
    // table change mid-character.
    always_comb begin
        g_valid_d = g_valid_q;
        g_cur_d   = g_cur_q;
        g_chr_d   = g_chr_q;
        g_nxt_d   = g_nxt_q;
        fail_d    = fail_q;
        out_d     = out_q;
        if (fsm_q == IDLE && TBL_WE) begin
            for (int unsigned i = 0; i < GOTO_DEPTH; i++) begin
                if (TBL_SEL == 2'd0 && 32'(TBL_ADDR) == i) begin
                    g_valid_d[i] = TBL_WDATA[2*STATE_W+CHAR_W];
                    g_cur_d[i]   = TBL_WDATA[2*STATE_W+CHAR_W-1 -: STATE_W];
                    g_chr_d[i]   = TBL_WDATA[STATE_W+CHAR_W-1 -: CHAR_W];
                    g_nxt_d[i]   = TBL_WDATA[STATE_W-1:0];
                end
            end
            for (int unsigned i = 0; i < NUM_STATES; i++) begin
                if (TBL_SEL == 2'd1 && 32'(TBL_ADDR) == i) fail_d[i] = TBL_WDATA[STATE_W-1:0];
                if (TBL_SEL == 2'd2 && 32'(TBL_ADDR) == i) out_d[i]  = TBL_WDATA[ID_W-1:0];
            end
        end
    end

    // Parallel goto search (lowest index wins) and bounded table reads;
    // states beyond the table depth read as zero.
    always_comb begin
        hit     = 1'b0;
        hit_nxt = '0;
        fail_rd = '0;
        out_rd  = '0;
        for (int unsigned i = 0; i < GOTO_DEPTH; i++) begin
            if (!hit && g_valid_q[i] && g_cur_q[i] == state_q && g_chr_q[i] == char_q) begin
                hit     = 1'b1;
                hit_nxt = g_nxt_q[i];
            end
        end
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            if (32'(state_q) == i) fail_rd = fail_q[i];
            if (32'(hit_nxt) == i) out_rd  = out_q[i];
        end
    end

    // Next-state logic.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        pos_d    = pos_q;
        hop_d    = hop_q;
        char_d   = char_q;
        last_d   = last_q;
        mv_d     = 1'b0;
        mid_d    = mid_q;
        mpos_d   = mpos_q;
        err_d    = err_q;
        complete = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (IN_VALID) begin
                    char_d = IN_CHAR;
                    last_d = IN_LAST;
                    hop_d  = '0;
                    fsm_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_d  = hit_nxt;
                    complete = 1'b1;
                    if (out_rd != '0) begin
                        mv_d   = 1'b1;
                        mid_d  = out_rd;
                        mpos_d = pos_q;
                    end
                end else if (state_q == '0) begin
                    complete = 1'b1;
                end else if (hop_q == HOP_W'(NUM_STATES - 1)) begin
                    // This hop would bring the count to NUM_STATES: the chain
                    // is cyclic, so abandon the character at the root.
                    state_d  = '0;
                    err_d    = 1'b1;
                    complete = 1'b1;
                end else begin
                    state_d = fail_rd;
                    hop_d   = hop_q + 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
        if (complete) begin
            fsm_d = IDLE;
            pos_d = pos_q + 1'b1;
            if (last_q) begin
                state_d = '0;
                pos_d   = '0;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            pos_q   <= '0;
            hop_q   <= '0;
            char_q  <= '0;
            last_q  <= 1'b0;
            mv_q    <= 1'b0;
            mid_q   <= '0;
            mpos_q  <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < GOTO_DEPTH; i++) begin
                g_valid_q[i] <= 1'b0;
                g_cur_q[i]   <= '0;
                g_chr_q[i]   <= '0;
                g_nxt_q[i]   <= '0;
            end
            for (int unsigned i = 0; i < NUM_STATES; i++) begin
                fail_q[i] <= '0;
                out_q[i]  <= '0;
            end
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            pos_q     <= pos_d;
            hop_q     <= hop_d;
            char_q    <= char_d;
            last_q    <= last_d;
            mv_q      <= mv_d;
            mid_q     <= mid_d;
            mpos_q    <= mpos_d;
            err_q     <= err_d;
            g_valid_q <= g_valid_d;
            g_cur_q   <= g_cur_d;
            g_chr_q   <= g_chr_d;
            g_nxt_q   <= g_nxt_d;
            fail_q    <= fail_d;
            out_q     <= out_d;
        end
    end

    // Outputs.
    always_comb begin
        IN_READY    = (fsm_q == IDLE);
        BUSY        = (fsm_q != IDLE);
        MATCH_VALID = mv_q;
        MATCH_ID    = mid_q;
        MATCH_POS   = mpos_q;
        STATE_OUT   = state_q;
        ERR         = err_q;
    end

endmodule

// File: tb/tb_ac_stream_matcher.sv
// Testbench for ac_stream_matcher: the reference model tracks the automaton
// as "longest stream suffix that is a prefix of a pattern", derived directly
// from the pattern strings {he, she, his, hers}.
module tb_ac_stream_matcher;

    localparam int NS = 32;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [7:0]  IN_CHAR = '0;
    logic        IN_LAST = 1'b0;
    logic        IN_READY;
    logic        TBL_WE = 1'b0;
    logic [1:0]  TBL_SEL = '0;
    logic [7:0]  TBL_ADDR = '0;
    logic [24:0] TBL_WDATA = '0;
    logic        MATCH_VALID;
    logic [3:0]  MATCH_ID;
    logic [3:0]  MATCH_POS;
    logic [7:0]  STATE_OUT;
    logic        BUSY;
    logic        ERR;

    ac_stream_matcher #(.NUM_STATES(NS), .POS_W(4)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_CHAR(IN_CHAR),
        .IN_LAST(IN_LAST), .IN_READY(IN_READY), .TBL_WE(TBL_WE),
        .TBL_SEL(TBL_SEL), .TBL_ADDR(TBL_ADDR), .TBL_WDATA(TBL_WDATA),
        .MATCH_VALID(MATCH_VALID), .MATCH_ID(MATCH_ID), .MATCH_POS(MATCH_POS),
        .STATE_OUT(STATE_OUT), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    string pats  [4]  = '{"he", "she", "his", "hers"};
    string nodes [10] = '{"", "h", "he", "s", "sh", "she", "hi", "his", "her", "hers"};

    string m_pref   = "";
    int    m_pos    = 0;
    bit    m_loaded = 0;

    bit    g_mv;
    int    g_id, g_pos, g_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit is_pref(input string s);
        if (s.len() == 0) return 1'b1;
        for (int i = 0; i < 4; i++)
            if (s.len() <= pats[i].len() && pats[i].substr(0, s.len() - 1) == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int node_of(input string s);
        for (int i = 0; i < 10; i++) if (nodes[i] == s) return i;
        return -1;
    endfunction

    function automatic int pat_id(input string s);
        for (int i = 0; i < 4; i++) if (pats[i] == s) return i + 1;
        return 0;
    endfunction

    function automatic string fail_of(input string p);
        for (int k = 1; k < p.len(); k++)
            if (is_pref(p.substr(k, p.len() - 1))) return p.substr(k, p.len() - 1);
        return "";
    endfunction

    function automatic string ext(input string p, input byte c);
        string t;
        t = {p, " "};
        t.putc(p.len(), c);
        return t;
    endfunction

    // Advance the model by one character and return the expected outcome.
    function automatic void model_step(input byte c, input bit last, output int cyc,
                                       output bit mv, output int id, output int pos);
        string p;
        string t;
        int    h;
        bit    done;
        p = m_loaded ? m_pref : "";
        h = 0; done = 0; mv = 0; id = 0; pos = m_pos;
        while (m_loaded && !done) begin
            t = ext(p, c);
            if (is_pref(t)) begin
                p = t; done = 1; id = pat_id(p); mv = (id != 0);
            end else if (p.len() == 0) begin
                done = 1;
            end else begin
                p = fail_of(p); h++;
            end
        end
        cyc    = 1 + h;
        m_pref = last ? "" : p;
        m_pos  = last ? 0 : (m_pos + 1) % 16;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!IN_READY && n < 200) begin tick(); n++; end
        if (!IN_READY) chk("ready_timeout", 32'(IN_READY), 1);
    endtask

    task automatic wait_done(output int cyc, output bit mv, output int id, output int pos);
        cyc = 0; mv = 0; id = 0; pos = 0;
        while (BUSY && cyc < 200) begin
            tick(); cyc++;
            if (MATCH_VALID) begin mv = 1; id = 32'(MATCH_ID); pos = 32'(MATCH_POS); end
        end
        if (BUSY) chk("busy_timeout", 32'(BUSY), 0);
    endtask

    task automatic accept(input byte c, input bit last);
        wait_ready();
        IN_VALID = 1'b1; IN_CHAR = c; IN_LAST = last;
        tick();
        IN_VALID = 1'b0; IN_LAST = 1'b0;
    endtask

    task automatic drive_char(input byte c, input bit last);
        accept(c, last);
        wait_done(g_cyc, g_mv, g_id, g_pos);
    endtask

    task automatic send(input byte c, input bit last);
        int e_cyc, e_id, e_pos;
        bit e_mv;
        model_step(c, last, e_cyc, e_mv, e_id, e_pos);
        drive_char(c, last);
        chk("cycles", g_cyc, e_cyc);
        chk("match_valid", 32'(g_mv), 32'(e_mv));
        if (e_mv) begin
            chk("match_id", g_id, e_id);
            chk("match_pos", g_pos, e_pos);
        end
        chk("state", 32'(STATE_OUT), m_loaded ? node_of(m_pref) : 0);
    endtask

    task automatic wr(input logic [1:0] sel, input int addr, input logic [24:0] d);
        wait_ready();
        TBL_WE = 1'b1; TBL_SEL = sel; TBL_ADDR = 8'(addr); TBL_WDATA = d;
        tick();
        TBL_WE = 1'b0;
    endtask

    task automatic load_tables();
        int  gc  [9] = '{0, 1, 2, 8, 1, 6, 0, 3, 4};
        byte gch [9] = '{"h", "e", "r", "s", "i", "s", "s", "h", "e"};
        int  gn  [9] = '{1, 2, 8, 9, 6, 7, 3, 4, 5};
        for (int i = 0; i < 9; i++) wr(2'd0, i, {1'b1, 8'(gc[i]), gch[i], 8'(gn[i])});
        wr(2'd1, 4, 25'd1); wr(2'd1, 5, 25'd2); wr(2'd1, 7, 25'd3); wr(2'd1, 9, 25'd3);
        wr(2'd2, 2, 25'd1); wr(2'd2, 5, 25'd2); wr(2'd2, 7, 25'd3); wr(2'd2, 9, 25'd4);
        m_loaded = 1;
    endtask

    task automatic send_str(input string s, input bit last_at_end);
        for (int i = 0; i < s.len(); i++) send(s[i], last_at_end && (i == s.len() - 1));
    endtask

    initial begin
        string alpha;
        string s;
        int    e_cyc, e_id, e_pos;
        bit    e_mv;
        alpha = "hersix";

        tick(); tick();
        RST = 1'b0;
        chk("rst_ready", 32'(IN_READY), 1);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_state", 32'(STATE_OUT), 0);
        chk("rst_mv", 32'(MATCH_VALID), 0);
        chk("rst_id", 32'(MATCH_ID), 0);
        chk("rst_pos", 32'(MATCH_POS), 0);
        chk("rst_err", 32'(ERR), 0);

        // Empty table: each character is a single-cycle root miss.
        send_str("xyz", 1);

        load_tables();
        s = "ushers";
        for (int i = 0; i < 6; i++) begin
            send(s[i], i == 5);
            if (i == 3) begin chk("ushers_id2", g_id, 2); chk("ushers_pos3", g_pos, 3); end
            if (i == 4) chk("ushers_r_cyc", g_cyc, 2);
            if (i == 5) begin chk("ushers_id4", g_id, 4); chk("ushers_pos5", g_pos, 5); end
        end
        chk("ushers_state", 32'(STATE_OUT), 0);
        chk("ushers_err", 32'(ERR), 0);

        // Position wrap with a 4-bit counter.
        for (int i = 0; i < 17; i++) send("x", 0);
        send_str("he", 1);
        chk("wrap_id", g_id, 1);
        chk("wrap_pos", g_pos, 2);

        // Table write while busy must be dropped.
        model_step("x", 0, e_cyc, e_mv, e_id, e_pos);
        accept("x", 0);
        chk("we_busy", 32'(BUSY), 1);
        TBL_WE = 1'b1; TBL_SEL = 2'd0; TBL_ADDR = 8'd0; TBL_WDATA = '0;
        tick();
        TBL_WE = 1'b0;
        wait_done(g_cyc, g_mv, g_id, g_pos);
        send_str("he", 1);
        chk("we_busy_kept", g_id, 1);

        // Same-cycle table write and character accept: the lookup sees it.
        wait_ready();
        TBL_WE = 1'b1; TBL_SEL = 2'd2; TBL_ADDR = 8'd1; TBL_WDATA = 25'd7;
        IN_VALID = 1'b1; IN_CHAR = "h"; IN_LAST = 1'b0;
        tick();
        TBL_WE = 1'b0; IN_VALID = 1'b0;
        wait_done(g_cyc, g_mv, g_id, g_pos);
        chk("we_same_cycle_id", g_id, 7);
        wr(2'd2, 1, 25'd0);
        model_step("h", 0, e_cyc, e_mv, e_id, e_pos);

        for (int i = 0; i < 150; i++) send(alpha[$urandom_range(0, 5)], $urandom_range(0, 7) == 0);

        // Reset during LOOKUP of 'e' in "she": aborted, tables wiped.
        send_str("sh", 0);
        accept("e", 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_mv", 32'(MATCH_VALID), 0);
        chk("abort_state", 32'(STATE_OUT), 0);
        chk("abort_busy", 32'(BUSY), 0);
        chk("abort_pos", 32'(MATCH_POS), 0);
        m_loaded = 0; m_pref = ""; m_pos = 0;
        send_str("she", 1);

        // Cyclic failure chain overruns the hop limit.
        wr(2'd0, 0, {1'b1, 8'd0, 8'("h"), 8'd1});
        wr(2'd1, 1, 25'd2);
        wr(2'd1, 2, 25'd1);
        drive_char("h", 0);
        chk("loop_state1", 32'(STATE_OUT), 1);
        chk("loop_err_before", 32'(ERR), 0);
        drive_char("q", 0);
        chk("loop_cycles", g_cyc, NS);
        chk("loop_mv", 32'(g_mv), 0);
        chk("loop_err", 32'(ERR), 1);
        chk("loop_state0", 32'(STATE_OUT), 0);
        chk("loop_ready", 32'(IN_READY), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
